// File: rtl/sys_state_ctrl_pkg.sv
// Shared encodings for the ECT system working-state sequencer.
// The LED indicator block imports the same SysStat constants.
package sys_state_ctrl_pkg;

  localparam int TIMER_W = 20;
  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WORK  = 2'b10,
    ST_FAULT = 2'b11
  } sys_stat_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_code_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_CHK_FAIL = 2'b01,
    FC_CHK_TMO  = 2'b10,
    FC_WDOG     = 2'b11
  } fault_code_e;

endpackage

// File: rtl/sys_state_ctrl_if.sv
// Command, self-check and measurement handshake bundle of the sequencer.
// master = host/decoder side, slave = sys_state_ctrl.
interface sys_state_ctrl_if;
  import sys_state_ctrl_pkg::*;

  logic               CmdValid;
  logic [1:0]         CmdCode;
  logic               CmdReady;
  logic               CmdErr;
  logic               ChkStart;
  logic               ChkDone;
  logic               ChkPass;
  logic               WorkEn;
  logic               FrameDone;
  logic [FRAME_W-1:0] FrameCnt;
  logic [1:0]         SysStat;
  logic               Fault;
  logic [1:0]         FaultCode;

  modport master (
    output CmdValid, CmdCode, ChkDone, ChkPass, FrameDone,
    input  CmdReady, CmdErr, ChkStart, WorkEn, FrameCnt, SysStat, Fault, FaultCode
  );

  modport slave (
    input  CmdValid, CmdCode, ChkDone, ChkPass, FrameDone,
    output CmdReady, CmdErr, ChkStart, WorkEn, FrameCnt, SysStat, Fault, FaultCode
  );

endinterface

// File: rtl/sys_state_ctrl_state_timer.sv
// Shared state timer: sync clear, saturating count, compare against a terminal value.
module sys_state_ctrl_state_timer
  import sys_state_ctrl_pkg::*;
(
  input  logic               CLK1M,
  input  logic               RST,
  input  logic               clr,
  input  logic [TIMER_W-1:0] term,
  output logic [TIMER_W-1:0] count,
  output logic               hit
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge CLK1M or negedge RST) begin
    if (!RST) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (count_reg != {TIMER_W{1'b1}}) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign hit   = (count_reg == term);

endmodule

// File: rtl/sys_state_ctrl.sv
// ECT system working-state sequencer: IDLE/CHECK/WORK/FAULT with registered outputs.
// Optional frame watchdog in WORK is enabled by defining SYS_WATCHDOG_EN.
module sys_state_ctrl
  import sys_state_ctrl_pkg::*;
#(
  parameter logic [19:0] CHECK_TIMEOUT = 20'd500000,
  parameter logic [19:0] FAULT_HOLD    = 20'd1000000,
  parameter logic [19:0] WD_TIMEOUT    = 20'd200000
) (
  input  logic           CLK1M,
  input  logic           RST,
  sys_state_ctrl_if.slave bus
);

  sys_stat_e          state_reg, state_next;
  fault_code_e        fault_code_reg, fault_code_next;
  logic               cmd_ready_reg;
  logic               cmd_err_reg, cmd_err_next;
  logic               chk_start_reg;
  logic               work_en_reg;
  logic               fault_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;

  logic               cmd_acc;
  cmd_code_e          cmd;
  logic               timer_clr;
  logic [TIMER_W-1:0] timer_term;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_hit;

  assign cmd_acc    = bus.CmdValid && cmd_ready_reg;
  assign cmd        = cmd_code_e'(bus.CmdCode);
  assign timer_term = (state_reg == ST_WORK) ? WD_TIMEOUT : CHECK_TIMEOUT;

  sys_state_ctrl_state_timer u_timer (
    .CLK1M (CLK1M),
    .RST   (RST),
    .clr   (timer_clr),
    .term  (timer_term),
    .count (timer_count),
    .hit   (timer_hit)
  );

  // Next-state decision; an illegal command only raises CmdErr and never blocks events.
  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    cmd_err_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_acc && cmd == CMD_START) state_next = ST_CHECK;
        if (cmd_acc && cmd == CMD_CLEAR) cmd_err_next = 1'b1;
      end
      ST_CHECK: begin
        if (cmd_acc && cmd == CMD_STOP) begin
          state_next = ST_IDLE;
        end else begin
          if (cmd_acc && (cmd == CMD_START || cmd == CMD_CLEAR)) cmd_err_next = 1'b1;
          if (bus.ChkDone) begin
            if (bus.ChkPass) begin
              state_next = ST_WORK;
            end else begin
              state_next      = ST_FAULT;
              fault_code_next = FC_CHK_FAIL;
            end
          end else if (timer_hit) begin
            state_next      = ST_FAULT;
            fault_code_next = FC_CHK_TMO;
          end
        end
      end
      ST_WORK: begin
        if (cmd_acc && cmd == CMD_STOP) begin
          state_next = ST_IDLE;
        end else begin
          if (cmd_acc && (cmd == CMD_START || cmd == CMD_CLEAR)) cmd_err_next = 1'b1;
`ifdef SYS_WATCHDOG_EN
          if (timer_hit && !bus.FrameDone) begin
            state_next      = ST_FAULT;
            fault_code_next = FC_WDOG;
          end
`endif
        end
      end
      ST_FAULT: begin
        if (cmd_acc) begin
          if (cmd == CMD_CLEAR && timer_count >= FAULT_HOLD) begin
            state_next      = ST_IDLE;
            fault_code_next = FC_NONE;
          end else if (cmd != CMD_NOP) begin
            cmd_err_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef SYS_WATCHDOG_EN
  assign timer_clr = (state_next != state_reg) || (state_reg == ST_WORK && bus.FrameDone);
`else
  assign timer_clr = (state_next != state_reg);
`endif

  always_ff @(posedge CLK1M or negedge RST) begin
    if (!RST) begin
      state_reg      <= ST_IDLE;
      fault_code_reg <= FC_NONE;
      cmd_ready_reg  <= 1'b0;
      cmd_err_reg    <= 1'b0;
      chk_start_reg  <= 1'b0;
      work_en_reg    <= 1'b0;
      fault_reg      <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
      cmd_ready_reg  <= 1'b1;
      cmd_err_reg    <= cmd_err_next;
      chk_start_reg  <= (state_next == ST_CHECK) && (state_reg != ST_CHECK);
      work_en_reg    <= (state_next == ST_WORK);
      fault_reg      <= (state_next == ST_FAULT);
      // Count restarts on START and again on WORK entry; a frame on the STOP cycle still counts.
      if ((state_reg == ST_IDLE && state_next == ST_CHECK) ||
          (state_reg != ST_WORK && state_next == ST_WORK)) begin
        frame_cnt_reg <= '0;
      end else if (state_reg == ST_WORK && bus.FrameDone &&
                   frame_cnt_reg != {FRAME_W{1'b1}}) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.SysStat   = state_reg;
  assign bus.FaultCode = fault_code_reg;
  assign bus.CmdReady  = cmd_ready_reg;
  assign bus.CmdErr    = cmd_err_reg;
  assign bus.ChkStart  = chk_start_reg;
  assign bus.WorkEn    = work_en_reg;
  assign bus.Fault     = fault_reg;
  assign bus.FrameCnt  = frame_cnt_reg;

endmodule

// File: doc/sys_state_ctrl.md
# sys_state_ctrl

System working-state sequencer for the ECT board. Accepts start/stop/clear commands from the host command decoder, runs the power-on self-check handshake, gates the measurement datapath, and publishes the 2-bit system state consumed by the indicator LED block. All timing runs on the 1 MHz housekeeping clock.

## Interface

Parameters:
- CHECK_TIMEOUT, 20'd500000: cycles allowed in CHECK for ChkDone (0.5 s)
- FAULT_HOLD, 20'd1000000: minimum cycles in FAULT before CLEAR is honoured (1 s)
- WD_TIMEOUT, 20'd200000: WORK-state frame watchdog limit (macro-gated)

Ports:
- CLK1M  in  1  1 MHz clock
- RST  in  1  reset, asynchronous, active-low
- CmdValid  in  1  command strobe from decoder
- CmdCode  in  2  00 NOP, 01 START, 10 STOP, 11 CLEAR
- CmdReady  out  1  command accept; constant 1 out of reset
- CmdErr  out  1  one-cycle pulse: accepted command illegal in current state
- ChkStart  out  1  one-cycle pulse launching self-check
- ChkDone  in  1  self-check complete pulse
- ChkPass  in  1  self-check result, sampled with ChkDone
- WorkEn  out  1  measurement datapath enable
- FrameDone  in  1  one pulse per completed frame
- FrameCnt  out  16  frames since last START, saturating
- SysStat  out  2  00 Idle, 01 Check, 10 Work, 11 Fault
- Fault  out  1  high in FAULT
- FaultCode  out  2  00 none, 01 check fail, 10 check timeout, 11 watchdog

## Operation

- Reset values: SysStat=00, CmdReady=0, CmdErr=0, ChkStart=0, WorkEn=0, FrameCnt=0, Fault=0, FaultCode=00. CmdReady=1 from first clock after reset release.
- Command accepted when CmdValid&&CmdReady; NOP accepted silently. Illegal accepted commands pulse CmdErr, no state change.
- IDLE: START -> CHECK. STOP -> no-op (legal). CLEAR -> CmdErr.
- CHECK: ChkStart high on the first CHECK cycle only. ChkDone&&ChkPass -> WORK. ChkDone&&!ChkPass -> FAULT, code 01. Timer reaches CHECK_TIMEOUT without ChkDone -> FAULT, code 10. STOP -> IDLE (abort). START/CLEAR -> CmdErr. STOP and ChkDone same cycle: STOP wins.
- WORK: WorkEn=1. FrameCnt cleared on entry, +1 per FrameDone, holds at 16'hFFFF. STOP -> IDLE. START/CLEAR -> CmdErr. FrameCnt retained after leaving WORK until next START.
- FAULT: WorkEn=0, Fault=1. CLEAR with timer >= FAULT_HOLD -> IDLE, FaultCode -> 00. Earlier CLEAR, START, STOP -> CmdErr.
- Single 20-bit state timer, cleared on every state entry, counts each cycle, saturates at all-ones.

## Timing

- All outputs registered. Command or event sampled at edge N -> SysStat, WorkEn, Fault, FaultCode, CmdErr updated at edge N.
- ChkStart asserted at the same edge SysStat becomes 01, low next edge.
- Timeout: FAULT entered at edge where timer == CHECK_TIMEOUT, i.e. CHECK_TIMEOUT+1 cycles after entry.
- WorkEn drops the edge STOP is accepted; a FrameDone in that same cycle is still counted.
- RST low mid-operation: all outputs to reset values immediately, no pending command retained.

## Configuration

- SYS_WATCHDOG_EN defined: in WORK, timer cleared by each FrameDone; timer == WD_TIMEOUT -> FAULT, code 11, WorkEn dropped same edge.
- Undefined: no watchdog, WORK exits only on STOP, FaultCode never 11, WD_TIMEOUT unused.

## Structure

- Shared package: SysStat encodings (Idle/Check/Work/Fault), CmdCode values, FaultCode values; indicator block uses the same state constants.
- One sub-module: state_timer (20-bit counter, sync clear, saturate, terminal-compare input).

## Test plan

- CHECK_TIMEOUT=100: START, ChkDone&&ChkPass at cycle 10 -> SysStat 00->01->10, one ChkStart pulse, WorkEn=1.
- START, no ChkDone -> FAULT at 101 cycles after entry, FaultCode=10; CLEAR at FAULT cycle 50 with FAULT_HOLD=200 -> CmdErr, stays FAULT; CLEAR at cycle 250 -> IDLE, FaultCode=00.
- In WORK, 70000 FrameDone pulses -> FrameCnt=16'hFFFF; STOP -> IDLE, FrameCnt holds; START -> FrameCnt=0.
- In CHECK, STOP and ChkDone&&!ChkPass same cycle -> IDLE, Fault=0.
- START in WORK, CLEAR in IDLE -> one CmdErr pulse each, SysStat unchanged.
- SYS_WATCHDOG_EN, WD_TIMEOUT=50: WORK with no FrameDone -> FAULT, code 11; RST low mid-WORK -> all outputs reset asynchronously.
